// File: rtl/parc_mem_port_arb.sv
// Shares one memory request port between an instruction port (0) and a data port (1).
// An in-order ID FIFO routes each memory response back to the port that issued it.
module parc_mem_port_arb #(
    parameter int unsigned p_addr_sz = 32,
    parameter int unsigned p_data_sz = 32,
    parameter int unsigned p_max_out = 4,
    localparam int unsigned c_len_sz  = $clog2(p_data_sz / 8),
    localparam int unsigned c_req_sz  = 1 + p_addr_sz + c_len_sz + p_data_sz,
    localparam int unsigned c_resp_sz = 1 + c_len_sz + p_data_sz,
    localparam int unsigned c_cnt_sz  = $clog2(p_max_out) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [c_req_sz-1:0]  req0_msg,
    input  logic                 req0_val,
    output logic                 req0_rdy,
    output logic [c_resp_sz-1:0] resp0_msg,
    output logic                 resp0_val,
    input  logic [c_req_sz-1:0]  req1_msg,
    input  logic                 req1_val,
    output logic                 req1_rdy,
    output logic [c_resp_sz-1:0] resp1_msg,
    output logic                 resp1_val,
    output logic [c_req_sz-1:0]  memreq_msg,
    output logic                 memreq_val,
    input  logic                 memreq_rdy,
    input  logic [c_resp_sz-1:0] memresp_msg,
    input  logic                 memresp_val,
    output logic [c_cnt_sz-1:0]  num_out,
    output logic                 err
);

    localparam int unsigned c_ptr_sz = $clog2(p_max_out);

    logic                 prio_q;
    logic                 err_q;
    logic [c_cnt_sz-1:0]  count_q;
    logic [c_ptr_sz-1:0]  head_q;
    logic [c_ptr_sz-1:0]  tail_q;
    logic [p_max_out-1:0] ids_q;

    logic full_c;
    logic grant0_c;
    logic grant1_c;
    logic fire_c;
    logic pop_c;
    logic head_id_c;

    // Grant depends only on the valids and prio, never on memreq_rdy.
    always_comb begin
        full_c    = (count_q == c_cnt_sz'(p_max_out));
        grant1_c  = req1_val & (~req0_val | prio_q);
        grant0_c  = req0_val & ~grant1_c;
        head_id_c = ids_q[head_q];
        fire_c    = 1'b0;
        pop_c     = 1'b0;

        memreq_val = (req0_val | req1_val) & ~full_c & ~reset;
        memreq_msg = grant1_c ? req1_msg : req0_msg;
        req0_rdy   = grant0_c & memreq_rdy & ~full_c & ~reset;
        req1_rdy   = grant1_c & memreq_rdy & ~full_c & ~reset;
        fire_c     = memreq_val & memreq_rdy;

        pop_c      = memresp_val & (count_q != '0) & ~reset;
        resp0_msg  = memresp_msg;
        resp1_msg  = memresp_msg;
        resp0_val  = pop_c & ~head_id_c;
        resp1_val  = pop_c & head_id_c;

        num_out    = reset ? '0 : count_q;
        err        = err_q & ~reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q  <= 1'b1;
            err_q   <= 1'b0;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            if (fire_c) begin
                tail_q <= tail_q + c_ptr_sz'(1);
                prio_q <= ~grant1_c;
            end
            if (pop_c) begin
                head_q <= head_q + c_ptr_sz'(1);
            end
            case ({fire_c, pop_c})
                2'b10:   count_q <= count_q + c_cnt_sz'(1);
                2'b01:   count_q <= count_q - c_cnt_sz'(1);
                default: count_q <= count_q;
            endcase
            // A response with nothing outstanding is dropped and flagged until reset.
            if (memresp_val && (count_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read once pushed.
    always_ff @(posedge clk) begin
        if (fire_c) begin
            ids_q[tail_q] <= grant1_c;
        end
    end

endmodule
